acc_mlp_seq: RTL and testbench

- Parametrised, time-multiplexed successor to the fixed 4-2-1 neuron pipeline.
- Computes a two-layer MLP: N_IN inputs, N_HID hidden neurons, 1 output neuron.
- Uses one shared MAC/clamp datapath sequenced by an FSM, not one neuron instance per node.
- Weights and biases are runtime-loadable through a config write port; data moves in and out on valid/ready handshakes.

---
 rtl/acc_pkg.sv | 34 +++
 rtl/acc_mlp_seq_if.sv | 28 ++
 rtl/mac_clamp.sv | 41 ++++
 rtl/acc_mlp_seq.sv | 178 +++++++++++++++++
 tb/tb_acc_mlp_seq.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared types and helpers for the time-multiplexed MLP.
// FSM states, width helpers and the signed clamp used by both layers.
package acc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      L1,
      L2,
      DONE
   } state_t;

   function automatic int fan_f(input int n_in, input int n_hid);
      return (n_in > n_hid) ? n_in : n_hid;
   endfunction

   function automatic int addr_w_f(input int n_in, input int n_hid);
      return $clog2((n_hid + 1) * (fan_f(n_in, n_hid) + 1));
   endfunction

   function automatic int acc_w_f(input int dw, input int n_in,
                                  input int n_hid);
      return 2 * dw + $clog2(fan_f(n_in, n_hid)) + 1;
   endfunction

   function automatic logic signed [63:0] clamp(
      input logic signed [63:0] v,
      input logic signed [63:0] lo,
      input logic signed [63:0] hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/acc_mlp_seq_if.sv
// Data, result and config bundle for acc_mlp_seq.
// master drives vectors/config, slave is the MLP.
interface acc_mlp_seq_if #(
   parameter int DW     = 8,
   parameter int N_IN   = 4,
   parameter int ADDR_W = 4
);
   logic [N_IN*DW-1:0] X;
   logic               valid;
   logic               ready;
   logic [DW-1:0]      Y;
   logic               valid_out;
   logic               ready_out;
   logic               cfg_we;
   logic [ADDR_W-1:0]  cfg_addr;
   logic [2*DW-1:0]    cfg_wdata;
   logic               busy;

   modport master (
      output X, valid, ready_out, cfg_we, cfg_addr, cfg_wdata,
      input  ready, Y, valid_out, busy
   );

   modport slave (
      input  X, valid, ready_out, cfg_we, cfg_addr, cfg_wdata,
      output ready, Y, valid_out, busy
   );
endinterface

// File: rtl/mac_clamp.sv
// Shared multiply-accumulate with shift and clamp.
// init loads bias + a*b, en adds a*b, y is the clamped activation.
module mac_clamp
   import acc_pkg::*;
#(
   parameter int DW    = 8,
   parameter int ACC_W = 19,
   parameter int SHIFT = 0,
   parameter int XMIN  = -127,
   parameter int XMAX  = 127
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init,
   input  logic                 en,
   input  logic signed [DW-1:0]   a,
   input  logic signed [DW-1:0]   b,
   input  logic signed [2*DW-1:0] bias,
   output logic signed [DW-1:0]   y
);
   logic signed [2*DW-1:0]  prod;
   logic signed [ACC_W-1:0] prod_x;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sh;

   assign prod   = a * b;
   assign prod_x = ACC_W'(prod);

   // accumulator: bias+product on the first term, then running sum
   always_ff @(posedge clk) begin
      if (rst)
         acc <= '0;
      else if (init)
         acc <= ACC_W'(bias) + prod_x;
      else if (en)
         acc <= acc + prod_x;
   end

   assign sh = acc >>> SHIFT;
   assign y  = DW'(clamp(64'(sh), 64'(XMIN), 64'(XMAX)));
endmodule

// File: rtl/acc_mlp_seq.sv
// Two-layer MLP on one shared MAC, sequenced by an FSM.
// Weights/biases are loaded through the config port while idle.
module acc_mlp_seq
   import acc_pkg::*;
#(
   parameter int DW    = 8,
   parameter int N_IN  = 4,
   parameter int N_HID = 2,
   parameter int SHIFT = 0,
   parameter int XMIN  = -127,
   parameter int XMAX  = 127
) (
   input logic          clk,
   input logic          arst,
   acc_mlp_seq_if.slave bus
);
   localparam int FAN    = fan_f(N_IN, N_HID);
   localparam int ADDR_W = addr_w_f(N_IN, N_HID);
   localparam int ACC_W  = acc_w_f(DW, N_IN, N_HID);
   localparam int KW     = $clog2(FAN + 1);
   localparam int JW     = $clog2(N_HID + 1);

   state_t state;
   logic [KW-1:0] k;
   logic [KW-1:0] k_last;
   logic [JW-1:0] j;

   logic signed [DW-1:0]   xr   [N_IN];
   logic signed [DW-1:0]   h    [N_HID];
   logic signed [DW-1:0]   w    [N_HID+1][FAN];
   logic signed [2*DW-1:0] bias [N_HID+1];

   logic signed [DW-1:0]   op_a;
   logic signed [DW-1:0]   op_b;
   logic signed [2*DW-1:0] op_bias;
   logic signed [DW-1:0]   act;
   logic                   mac_init;
   logic                   mac_en;

   logic          rdy_q;
   logic          vout_q;
   logic          busy_q;
   logic [DW-1:0] y_q;

   assign bus.ready     = rdy_q;
   assign bus.valid_out = vout_q;
   assign bus.busy      = busy_q;
   assign bus.Y         = y_q;

   // operand select for the current layer, neuron and term
   always_comb begin
      op_a    = '0;
      op_b    = '0;
      op_bias = '0;
      k_last  = KW'(N_IN);
      if (state == L2) begin
         k_last  = KW'(N_HID);
         op_bias = bias[N_HID];
         for (int i = 0; i < N_HID; i++)
            if (k == KW'(i)) begin
               op_a = h[i];
               op_b = w[N_HID][i];
            end
      end else begin
         op_bias = bias[j];
         for (int i = 0; i < N_IN; i++)
            if (k == KW'(i)) begin
               op_a = xr[i];
               op_b = w[j][i];
            end
      end
      mac_init = (state == L1 || state == L2) && (k == '0);
      mac_en   = (state == L1 || state == L2) && (k != '0) &&
                 (k != k_last);
   end

   mac_clamp #(
      .DW    (DW),
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .XMIN  (XMIN),
      .XMAX  (XMAX)
   ) u_mac (
      .clk  (clk),
      .rst  (arst),
      .init (mac_init),
      .en   (mac_en),
      .a    (op_a),
      .b    (op_b),
      .bias (op_bias),
      .y    (act)
   );

   // weight/bias register file, writable only while idle
   always_ff @(posedge clk) begin
      if (arst) begin
         for (int jj = 0; jj <= N_HID; jj++) begin
            bias[jj] <= '0;
            for (int kk = 0; kk < FAN; kk++)
               w[jj][kk] <= '0;
         end
      end else if (bus.cfg_we && state == IDLE) begin
         for (int jj = 0; jj <= N_HID; jj++) begin
            for (int kk = 0; kk < FAN; kk++)
               if (bus.cfg_addr == ADDR_W'(jj * (FAN + 1) + kk))
                  w[jj][kk] <= bus.cfg_wdata[DW-1:0];
            if (bus.cfg_addr == ADDR_W'(jj * (FAN + 1) + FAN))
               bias[jj] <= bus.cfg_wdata;
         end
      end
   end

   // sequencer: accept, hidden layer, output neuron, hold result
   always_ff @(posedge clk) begin
      if (arst) begin
         state  <= IDLE;
         k      <= '0;
         j      <= '0;
         rdy_q  <= 1'b0;
         vout_q <= 1'b0;
         busy_q <= 1'b0;
         y_q    <= '0;
         for (int i = 0; i < N_IN; i++)
            xr[i] <= '0;
         for (int i = 0; i < N_HID; i++)
            h[i] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.valid && rdy_q) begin
                  for (int i = 0; i < N_IN; i++)
                     xr[i] <= bus.X[i*DW +: DW];
                  k      <= '0;
                  j      <= '0;
                  rdy_q  <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= L1;
               end else begin
                  rdy_q <= 1'b1;
               end
            end
            L1: begin
               if (k == k_last) begin
                  h[j] <= act;
                  k    <= '0;
                  if (j == JW'(N_HID - 1)) begin
                     j     <= '0;
                     state <= L2;
                  end else begin
                     j <= j + 1'b1;
                  end
               end else begin
                  k <= k + 1'b1;
               end
            end
            L2: begin
               if (k == k_last) begin
                  y_q    <= act;
                  vout_q <= 1'b1;
                  k      <= '0;
                  state  <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               if (vout_q && bus.ready_out) begin
                  vout_q <= 1'b0;
                  rdy_q  <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_acc_mlp_seq.sv
// Directed and random checks of acc_mlp_seq at default parameters.
// Expected results come from a plain-arithmetic MLP model.
module tb_acc_mlp_seq;
   localparam int LAT = 13;

   logic clk = 1'b0;
   logic arst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   // model memory, indexed by config address (neuron*5 + slot)
   int mem [15];

   acc_mlp_seq_if #(.DW(8), .N_IN(4), .ADDR_W(4)) bus ();

   acc_mlp_seq #(
      .DW(8), .N_IN(4), .N_HID(2), .SHIFT(0), .XMIN(-127), .XMAX(127)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clampi(input longint v);
      if (v < -127) return -127;
      if (v > 127) return 127;
      return int'(v);
   endfunction

   function automatic int model(input int x [4]);
      int     hv [2];
      longint s;
      for (int n = 0; n < 2; n++) begin
         s = mem[n*5 + 4];
         for (int i = 0; i < 4; i++)
            s += longint'(x[i]) * mem[n*5 + i];
         hv[n] = clampi(s);
      end
      s = mem[14];
      for (int i = 0; i < 2; i++)
         s += longint'(hv[i]) * mem[10 + i];
      return clampi(s);
   endfunction

   function automatic void mem_wr(input int a, input int v);
      logic [15:0] v16;
      logic [7:0]  v8;
      v16 = 16'(v);
      v8  = 8'(v);
      if (a < 15) begin
         if (a % 5 == 4) mem[a] = int'($signed(v16));
         else mem[a] = int'($signed(v8));
      end
   endfunction

   task automatic cfg(input int a, input int v);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 4'(a);
      bus.cfg_wdata = 16'(v);
      tick;
      bus.cfg_we = 1'b0;
      mem_wr(a, v);
   endtask

   task automatic drive_x(input int x [4]);
      for (int i = 0; i < 4; i++)
         bus.X[i*8 +: 8] = 8'(x[i]);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!bus.ready && n < 40) begin
         tick;
         n++;
      end
      chk({tag, "_ready"}, int'(bus.ready), 1);
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!bus.valid_out && n < 100) begin
         tick;
         n++;
      end
   endtask

   task automatic run_vec(input int x [4], input string tag);
      int e, n;
      e = model(x);
      wait_ready(tag);
      drive_x(x);
      bus.valid = 1'b1;
      tick;
      bus.valid = 1'b0;
      chk({tag, "_busy"}, int'(bus.busy), 1);
      wait_out(n);
      chk({tag, "_lat"}, n, LAT);
      chk({tag, "_y"}, int'($signed(bus.Y)), e);
      bus.ready_out = 1'b1;
      tick;
      bus.ready_out = 1'b0;
   endtask

   initial begin
      int x [4];
      int e, n, v;

      bus.X = '0;
      bus.valid = 1'b0;
      bus.ready_out = 1'b0;
      bus.cfg_we = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_wdata = '0;
      foreach (mem[i]) mem[i] = 0;

      // reset state
      tick;
      tick;
      chk("rst_ready", int'(bus.ready), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_vout", int'(bus.valid_out), 0);
      chk("rst_y", int'(bus.Y), 0);
      arst = 1'b0;
      tick;
      chk("ready_rise", int'(bus.ready), 1);

      // zero weights
      x = '{10, 20, 30, 40};
      run_vec(x, "zero");

      // identity path and hidden-layer clamp
      cfg(0, 1);
      cfg(10, 1);
      x = '{50, 7, 7, 7};
      run_vec(x, "ident");
      cfg(0, 2);
      x = '{-100, 7, 7, 7};
      run_vec(x, "hclamp");

      // saturation and bias
      cfg(0, 127);
      x = '{127, 0, 0, 0};
      run_vec(x, "sat");
      cfg(4, -300);
      x = '{0, 0, 0, 0};
      run_vec(x, "bias");

      // config in the same cycle as the accepted vector
      wait_ready("samecyc");
      x = '{5, 1, 1, 1};
      mem_wr(4, 0);
      e = model(x);
      drive_x(x);
      bus.valid = 1'b1;
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 4'd4;
      bus.cfg_wdata = 16'd0;
      tick;
      bus.valid = 1'b0;
      bus.cfg_we = 1'b0;
      wait_out(n);
      chk("samecyc_y", int'($signed(bus.Y)), e);
      bus.ready_out = 1'b1;
      tick;
      bus.ready_out = 1'b0;

      // backpressure
      x = '{-3, 0, 0, 0};
      e = model(x);
      wait_ready("bp");
      drive_x(x);
      bus.valid = 1'b1;
      tick;
      bus.valid = 1'b0;
      wait_out(n);
      chk("bp_lat", n, LAT);
      for (int i = 0; i < 5; i++) begin
         bus.valid = (i % 2 == 0);
         tick;
         chk("bp_vout", int'(bus.valid_out), 1);
         chk("bp_y", int'($signed(bus.Y)), e);
         chk("bp_ready", int'(bus.ready), 0);
      end
      bus.valid = 1'b0;
      bus.ready_out = 1'b1;
      tick;
      bus.ready_out = 1'b0;
      chk("bp_rel_ready", int'(bus.ready), 1);
      chk("bp_rel_vout", int'(bus.valid_out), 0);
      x = '{9, 0, 0, 0};
      run_vec(x, "bp_second");

      // config ignored while busy
      x = '{20, 0, 0, 0};
      e = model(x);
      wait_ready("cfgbusy");
      drive_x(x);
      bus.valid = 1'b1;
      tick;
      bus.valid = 1'b0;
      tick;
      tick;
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 4'd0;
      bus.cfg_wdata = 16'd5;
      tick;
      bus.cfg_we = 1'b0;
      n = 0;
      while (!bus.valid_out && n < 100) begin
         chk("cfgbusy_busy", int'(bus.busy), 1);
         tick;
         n++;
      end
      chk("cfgbusy_done_busy", int'(bus.busy), 1);
      chk("cfgbusy_y", int'($signed(bus.Y)), e);
      bus.ready_out = 1'b1;
      tick;
      bus.ready_out = 1'b0;
      run_vec(x, "cfgbusy_again");

      // reset during L1
      x = '{30, 30, 30, 30};
      wait_ready("midrst");
      drive_x(x);
      bus.valid = 1'b1;
      tick;
      bus.valid = 1'b0;
      repeat (6) tick;
      arst = 1'b1;
      tick;
      chk("midrst_vout", int'(bus.valid_out), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_ready", int'(bus.ready), 0);
      arst = 1'b0;
      foreach (mem[i]) mem[i] = 0;
      run_vec(x, "midrst_zero");

      // random configurations and vectors
      for (int it = 0; it < 8; it++) begin
         for (int a = 0; a < 16; a++) begin
            if (it % 2 == 0) v = int'($urandom_range(0, 31)) - 16;
            else v = int'($urandom_range(0, 65535));
            cfg(int'($urandom_range(0, 15)), v);
         end
         for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++)
               x[i] = int'($urandom_range(0, 255)) - 128;
            run_vec(x, "rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
